// File: rtl/mem_port_a_arbiter.sv
// Two-master arbiter for unified-memory port A: per-cycle round robin with an
// optional bounded lock, and one-cycle read return routed back to the issuing master.
module mem_port_a_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_LOCK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_req,
    input  logic [DATA_WIDTH/8-1:0]   m0_we,
    input  logic [ADDR_WIDTH-1:0]     m0_addr,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic                      m0_lock,
    output logic                      m0_gnt,
    output logic                      m0_rvalid,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    input  logic                      m1_req,
    input  logic [DATA_WIDTH/8-1:0]   m1_we,
    input  logic [ADDR_WIDTH-1:0]     m1_addr,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic                      m1_lock,
    output logic                      m1_gnt,
    output logic                      m1_rvalid,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic                      en_a,
    output logic [DATA_WIDTH/8-1:0]   we_a,
    output logic [ADDR_WIDTH-1:0]     addr_a,
    output logic [DATA_WIDTH-1:0]     din_a,
    input  logic [DATA_WIDTH-1:0]     dout_a,
    output logic                      busy
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK_CYCLES);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t      owner_r, owner_s;
    logic [7:0]  lock_cnt_r, lock_cnt_s;
    logic        last_gnt_r, last_gnt_s;
    logic [1:0]  rd_pend_r, rd_pend_s;

    logic        gnt0_s, gnt1_s;
    logic        owner_lock_s, force_rel_s, open_s;

    // Lock qualification: arbitration is open when nobody owns the port,
    // the owner drops its lock, or the owner has exhausted its wait budget.
    always_comb begin
        case (owner_r)
            OWN_M0:  owner_lock_s = m0_lock;
            OWN_M1:  owner_lock_s = m1_lock;
            default: owner_lock_s = 1'b0;
        endcase
        force_rel_s = (owner_r != OWN_NONE) && (lock_cnt_r >= MAX_CNT);
        open_s      = (owner_r == OWN_NONE) || !owner_lock_s || force_rel_s;
    end

    // Grant selection; a forced release hands priority to the waiting master.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (!open_s) begin
            if (owner_r == OWN_M0) begin
                gnt0_s = m0_req;
            end else begin
                gnt1_s = m1_req;
            end
        end else if (force_rel_s) begin
            if (owner_r == OWN_M0) begin
                gnt1_s = m1_req;
                gnt0_s = m0_req && !m1_req;
            end else begin
                gnt0_s = m0_req;
                gnt1_s = m1_req && !m0_req;
            end
        end else if (m0_req && m1_req) begin
            gnt0_s = last_gnt_r;
            gnt1_s = !last_gnt_r;
        end else begin
            gnt0_s = m0_req;
            gnt1_s = m1_req;
        end
    end

    // Port A mux; idle cycles park the address/data on M0 with no enables.
    always_comb begin
        en_a = gnt0_s || gnt1_s;
        if (gnt1_s) begin
            we_a   = m1_we;
            addr_a = m1_addr;
            din_a  = m1_wdata;
        end else begin
            we_a   = gnt0_s ? m0_we : {BE_WIDTH{1'b0}};
            addr_a = m0_addr;
            din_a  = m0_wdata;
        end
    end

    // Next-state computation for ownership, lock counter, round robin and read tracking.
    always_comb begin
        owner_s    = owner_r;
        lock_cnt_s = lock_cnt_r;
        if (force_rel_s) begin
            owner_s    = OWN_NONE;
            lock_cnt_s = 8'd0;
        end else if (open_s) begin
            lock_cnt_s = 8'd0;
            if (gnt0_s && m0_lock) begin
                owner_s = OWN_M0;
            end else if (gnt1_s && m1_lock) begin
                owner_s = OWN_M1;
            end else begin
                owner_s = OWN_NONE;
            end
        end else begin
            if ((owner_r == OWN_M0) ? m1_req : m0_req) begin
                lock_cnt_s = lock_cnt_r + 8'd1;
            end else begin
                lock_cnt_s = lock_cnt_r;
            end
        end

        if (gnt1_s) begin
            last_gnt_s = 1'b1;
        end else if (gnt0_s) begin
            last_gnt_s = 1'b0;
        end else begin
            last_gnt_s = last_gnt_r;
        end

        rd_pend_s = {gnt1_s && (m1_we == {BE_WIDTH{1'b0}}),
                     gnt0_s && (m0_we == {BE_WIDTH{1'b0}})};
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_r    <= OWN_NONE;
            lock_cnt_r <= 8'd0;
            last_gnt_r <= 1'b1;
            rd_pend_r  <= 2'b00;
        end else begin
            owner_r    <= owner_s;
            lock_cnt_r <= lock_cnt_s;
            last_gnt_r <= last_gnt_s;
            rd_pend_r  <= rd_pend_s;
        end
    end

    assign m0_gnt    = gnt0_s;
    assign m1_gnt    = gnt1_s;
    assign m0_rvalid = rd_pend_r[0];
    assign m1_rvalid = rd_pend_r[1];
    assign m0_rdata  = rd_pend_r[0] ? dout_a : {DATA_WIDTH{1'b0}};
    assign m1_rdata  = rd_pend_r[1] ? dout_a : {DATA_WIDTH{1'b0}};
    assign busy      = (owner_r != OWN_NONE);

endmodule
